sat_arith_pipe: RTL and testbench
=================================

// Module: sat_arith_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined saturating add/sub unit for the EX stage.
//  Supports full-width signed ADD/SUB and packed-lane saturating PADDSB/PSUBSB.
//  Uses a valid/ready handshake on both sides, so the unit can stall under hazards.
//  Holds an architectural V/N/Z flag register, written only by ops that request it.
// PARAMETERS
//  WIDTH   16  operand/result width in bits
//  LANE_W  4   lane width for packed modes; WIDTH % LANE_W != 0 -> elaboration error
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      op presented on A/B/op/flag_we
//  in_ready   out  1      unit can accept op this cycle
//  A          in   WIDTH  operand A (two's complement)
//  B          in   WIDTH  operand B (two's complement)
//  op         in   2      op[1]=subtract, op[0]=packed-lane mode
//                         00 ADD, 10 SUB, 01 PADDSB, 11 PSUBSB
//  flag_we    in   1      this op updates V/N/Z when its result is accepted
//  out_valid  out  1      result on Out is valid
//  out_ready  in   1      consumer accepts Out this cycle
//  Out        out  WIDTH  saturated result
//  V, N, Z    out  1      flag register outputs
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0 immediately -> Out, out_valid, V, N, Z.
//   in_ready=0 while rst_n=0; S1/S2 valid bits and all pipeline data cleared.
//  Arithmetic, per lane (lane = whole word when op[0]=0, else WIDTH/LANE_W lanes):
//   B' = op[1] ? ~B : B; sum = A + B' + op[1], with the carry confined to the lane.
//   ovf = (A_msb == B'_msb) && (sum_msb != A_msb).
//   On ovf: lane result = A_msb ? most-negative (0x8..) : most-positive (0x7F..).
//  Flag candidates, computed on the saturated result:
//   V = OR of lane ovf bits; N = result[WIDTH-1]; Z = (result == 0).
//  Pipeline:
//   S1 registers the per-lane raw sums, ovf bits, op and flag_we.
//   S2 registers the saturated result and flag candidates.
//   s2_adv = !s2_valid || out_ready;  s1_adv = !s1_valid || s2_adv;  in_ready = s1_adv.
//   Latency: op accepted on edge E0 -> out_valid=1 after edge E1, if no stall.
//   Throughput: 1 op/cycle.
//  Handshake rules:
//   Out/out_valid held stable while out_valid && !out_ready.
//   No ops dropped or duplicated; results leave in issue order.
//   Input accepted while out_ready=0 only if a slot is free.
//   Accept and retire in the same cycle are allowed (full-rate streaming).
//  Flag register: loads V/N/Z at the out_valid && out_ready edge if S2.flag_we=1.
//   Otherwise the flags hold their value.
//  Boundaries:
//   B = most-negative with SUB: handled by the ovf rule, no special case.
//   A - B with A == B: gives 0 and Z=1, never V.
//   LANE_W == WIDTH: packed modes equal scalar modes.
//   rst_n low mid-stall: in-flight ops discarded, flags cleared.
// STRUCTURE
//  Package sat_arith_pkg: op encodings OP_ADD/OP_SUB/OP_PADDSB/OP_PSUBSB and a
//   function sat_max(width)/sat_min(width).
//  Sub-module sat_lane_add (parameter LANE_W): inputs a, b, sub; outputs raw sum and ovf.
//   Instantiated WIDTH/LANE_W times in a generate loop.
//   The scalar path reuses the lanes via a carry-chain mux controlled by op[0].
// TESTING (WIDTH=16, LANE_W=4, out_ready=1 unless stated)
//  ADD 0x7FFF + 0x0001, flag_we=1 -> Out=0x7FFF, V=1 N=0 Z=0; out_valid 1 edge after accept.
//  SUB 0x8000 - 0x0001, flag_we=1 -> Out=0x8000, V=1 N=1 Z=0.
//   SUB 0x0000 - 0x8000 -> Out=0x7FFF, V=1.
//  SUB 0x1234 - 0x1234, flag_we=1 -> Out=0x0000, Z=1 V=0 N=0.
//   Follow with ADD 1+1, flag_we=0 -> Out=0x0002; flags stay Z=1.
//  PADDSB 0x7F18 + 0x1178 -> Out=0x7078, V=1.
//   PSUBSB 0x8000 - 0x1000 -> Out=0x8000, V=1.
//  Backpressure: out_ready=0, issue 3 back-to-back ops -> 2 accepted, then in_ready=0.
//   Out holds op#1; release out_ready -> ops 1,2,3 retire in order, none lost.
//  Reset: drop rst_n mid-stall with out_valid=1 and flags set.
//   Expect out_valid, V, N, Z = 0 before the next clk edge.
//   After release, the first new op completes normally.

Source files
------------

// File: rtl/sat_arith_pkg.sv
// Shared definitions for the saturating add/sub pipeline: op encodings and
// saturation bound helpers.
package sat_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_PADDSB = 2'b01,
    OP_SUB    = 2'b10,
    OP_PSUBSB = 2'b11
  } op_e;

  localparam int unsigned SAT_MAX_W = 64;

  // Most-positive two's complement value of the given width (0x7F..).
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned width);
    return (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
  endfunction

  // Most-negative two's complement value of the given width (0x80..).
  function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned width);
    return SAT_MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sat_lane_add.sv
// One lane of the add/sub datapath: raw sum, carry out, and signed overflow.
module sat_lane_add #(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic [LANE_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  logic [LANE_W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{LANE_W{1'b0}}, cin};

  // Only meaningful as a word overflow on the top lane when lanes are chained.
  assign ovf = (a[LANE_W-1] == b_eff[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);

endmodule

// File: rtl/sat_arith_pipe.sv
// Two-stage saturating add/sub unit (scalar and packed lanes) with valid/ready
// on both sides and an architectural V/N/Z flag register.
module sat_arith_pipe
  import sat_arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int NL = WIDTH / LANE_W;

  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(sat_max(LANE_W));
  localparam logic [LANE_W-1:0] LANE_MIN = LANE_W'(sat_min(LANE_W));
  localparam logic [WIDTH-1:0]  WORD_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0]  WORD_MIN = WIDTH'(sat_min(WIDTH));

  if ((WIDTH % LANE_W) != 0) begin : g_bad_lane_cfg
    $error("sat_arith_pipe: WIDTH must be a multiple of LANE_W");
  end
  if (WIDTH > int'(SAT_MAX_W)) begin : g_bad_width_cfg
    $error("sat_arith_pipe: WIDTH exceeds saturation helper range");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A stage advances when it is empty or its downstream stage advances; the
  // input is accepted exactly when stage 1 advances.
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && rst_n;

  // ---------------- Lane adders with scalar carry chain ----------------
  logic             packed_mode;
  logic             sub;
  logic [NL:0]      carry;
  logic [WIDTH-1:0] raw_sum;
  logic [NL-1:0]    lane_ovf;
  logic             unused_top_carry;

  assign packed_mode      = op[0];
  assign sub              = op[1];
  assign carry[0]         = sub;
  assign unused_top_carry = carry[NL];

  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic lane_cin;

    // Packed lanes each restart with the subtract carry; scalar mode ripples.
    assign lane_cin = packed_mode ? sub : carry[i];

    sat_lane_add #(
      .LANE_W (LANE_W)
    ) u_lane (
      .a    (A[i*LANE_W +: LANE_W]),
      .b    (B[i*LANE_W +: LANE_W]),
      .sub  (sub),
      .cin  (lane_cin),
      .sum  (raw_sum[i*LANE_W +: LANE_W]),
      .cout (carry[i+1]),
      .ovf  (lane_ovf[i])
    );
  end

  // ---------------- Stage 1: raw sums and overflow bits ----------------
  logic [WIDTH-1:0] s1_sum_q;
  logic [NL-1:0]    s1_ovf_q;
  logic             s1_packed_q;
  logic             s1_flag_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_ovf_q     <= '0;
      s1_packed_q  <= 1'b0;
      s1_flag_we_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_q     <= raw_sum;
        s1_ovf_q     <= lane_ovf;
        s1_packed_q  <= packed_mode;
        s1_flag_we_q <= flag_we;
      end
    end
  end

  // ---------------- Saturation and flag candidates ----------------
  // On overflow the raw sum MSB is the inverse of A's MSB, so it alone
  // selects the saturation direction.
  logic [WIDTH-1:0] sat_d;
  logic             v_d;
  logic             n_d;
  logic             z_d;

  always_comb begin
    sat_d = s1_sum_q;
    v_d   = 1'b0;
    if (s1_packed_q) begin
      for (int i = 0; i < NL; i++) begin
        if (s1_ovf_q[i]) begin
          sat_d[i*LANE_W +: LANE_W] = s1_sum_q[i*LANE_W + LANE_W - 1] ? LANE_MAX : LANE_MIN;
        end
      end
      v_d = |s1_ovf_q;
    end else if (s1_ovf_q[NL-1]) begin
      sat_d = s1_sum_q[WIDTH-1] ? WORD_MAX : WORD_MIN;
      v_d   = 1'b1;
    end
    n_d = sat_d[WIDTH-1];
    z_d = (sat_d == '0);
  end

  // ---------------- Stage 2: saturated result ----------------
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_v_q, s2_n_q, s2_z_q;
  logic             s2_flag_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_v_q       <= 1'b0;
      s2_n_q       <= 1'b0;
      s2_z_q       <= 1'b0;
      s2_flag_we_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q  <= sat_d;
        s2_v_q       <= v_d;
        s2_n_q       <= n_d;
        s2_z_q       <= z_d;
        s2_flag_we_q <= s1_flag_we_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign Out       = s2_result_q;

  // ---------------- Architectural flag register ----------------
  logic v_q, n_q, z_q;
  logic flag_load;

  assign flag_load = s2_valid_q && out_ready && s2_flag_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else if (flag_load) begin
      v_q <= s2_v_q;
      n_q <= s2_n_q;
      z_q <= s2_z_q;
    end
  end

  assign V = v_q;
  assign N = n_q;
  assign Z = z_q;

endmodule

// File: tb/tb_sat_arith_pipe.sv
// Self-checking bench for sat_arith_pipe (WIDTH=16, LANE_W=4): directed cases,
// backpressure ordering, mid-stall reset and randomized streaming vs a model.
module tb_sat_arith_pipe;
  import sat_arith_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   op;
  logic         flag_we;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic         V, N, Z;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   meta_q[$];   // {flag_we, v, n, z}
  logic [2:0]   exp_flags;   // {v, n, z}

  sat_arith_pipe #(.WIDTH(16), .LANE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .flag_we   (flag_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .V         (V),
    .N         (N),
    .Z         (Z)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Signed integer add/sub per lane, clamped to the lane range; returns {v, result}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] o);
    int lw, nl, av, bv, r, mx, mn, mask;
    logic [W-1:0] res;
    logic v;
    lw = o[0] ? 4 : 16;
    nl = W / lw;
    mask = (1 << lw) - 1;
    mx = (1 << (lw - 1)) - 1;
    mn = -(1 << (lw - 1));
    res = '0;
    v = 1'b0;
    for (int l = 0; l < nl; l++) begin
      av = int'(a >> (l * lw)) & mask;
      bv = int'(b >> (l * lw)) & mask;
      if (av > mx) av = av - (1 << lw);
      if (bv > mx) bv = bv - (1 << lw);
      r = o[1] ? av - bv : av + bv;
      if (r > mx) begin r = mx; v = 1'b1; end
      else if (r < mn) begin r = mn; v = 1'b1; end
      res = res | W'((r & mask) << (l * lw));
    end
    return {v, res};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] edges[6];
    edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7878};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs, samples outputs before the edge, returns after it.
  task automatic step(input logic iv, input logic [W-1:0] i_a, input logic [W-1:0] i_b,
                      input logic [1:0] i_op, input logic i_fwe, input logic i_ordy,
                      output logic acc, output logic ret, output logic vld,
                      output logic [W-1:0] rout);
    @(negedge clk);
    in_valid  = iv;
    A         = i_a;
    B         = i_b;
    op        = i_op;
    flag_we   = i_fwe;
    out_ready = i_ordy;
    #1;
    acc  = iv && in_ready;
    vld  = out_valid;
    ret  = out_valid && out_ready;
    rout = Out;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = 2'b00; flag_we = 1'b0; out_ready = 1'b1;
    exp_flags = 3'b000;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (Out !== 16'h0000) begin n_err++; $display("FAIL reset_out: got %h want 0000", Out); end
    n_vec++; if ({V, N, Z} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {V, N, Z}); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[8], tb_[8], tout[8];
    logic [1:0]   top_[8];
    logic         tfwe[8];
    logic [2:0]   tfl[8];
    logic acc, ret, vld;
    logic [W-1:0] rout;
    ta   = '{16'h7FFF, 16'h8000, 16'h0000, 16'h1234, 16'h0001, 16'h7F18, 16'h8000, 16'h8000};
    tb_  = '{16'h0001, 16'h0001, 16'h8000, 16'h1234, 16'h0001, 16'h1178, 16'h1000, 16'h8000};
    top_ = '{OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_ADD, OP_PADDSB, OP_PSUBSB, OP_SUB};
    tfwe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tout = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0002, 16'h7078, 16'h8000, 16'h0000};
    tfl  = '{3'b100, 3'b110, 3'b100, 3'b001, 3'b001, 3'b100, 3'b110, 3'b001};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ta[i], tb_[i], top_[i], tfwe[i], 1'b1, acc, ret, vld, rout);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL dir%0d_accept: got %b want 1", i, acc); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid); end
      step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, ret, vld, rout);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency: got out_valid=%b want 1", i, out_valid); end
      step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, ret, vld, rout);
      n_vec++; if (ret !== 1'b1 || rout !== tout[i]) begin
        n_err++; $display("FAIL dir%0d_result: got ret=%b Out=%h want ret=1 Out=%h", i, ret, rout, tout[i]);
      end
      n_vec++; if ({V, N, Z} !== tfl[i]) begin
        n_err++; $display("FAIL dir%0d_flags: got VNZ=%b want %b", i, {V, N, Z}, tfl[i]);
      end
      exp_flags = tfl[i];
    end
  endtask

  task automatic test_back_to_back();
    logic acc, ret, vld;
    logic [W-1:0] rout, held;
    logic [W-1:0] oa[3], ob[3];
    logic [1:0]   oo[3];
    logic [W:0]   r;
    logic op3_acc;
    int guard;
    oa = '{16'h0100, 16'h7FF0, 16'h4321};
    ob = '{16'h0023, 16'h0020, 16'h1234};
    oo = '{OP_ADD, OP_ADD, OP_PSUBSB};
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, oa[i], ob[i], oo[i], 1'b0, 1'b0, acc, ret, vld, rout);
      n_vec++; if (acc !== (i < 2)) begin n_err++; $display("FAIL b2b_accept%0d: got %b want %b", i, acc, (i < 2)); end
      if (acc) begin r = ref_op(oa[i], ob[i], oo[i]); exp_q.push_back(r[W-1:0]); end
    end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b1 || Out !== exp_q[0]) begin
      n_err++; $display("FAIL b2b_head: got v=%b Out=%h want v=1 Out=%h", out_valid, Out, exp_q[0]);
    end
    held = Out;
    step(1'b1, oa[2], ob[2], oo[2], 1'b0, 1'b0, acc, ret, vld, rout);
    n_vec++; if (out_valid !== 1'b1 || Out !== held || acc !== 1'b0) begin
      n_err++; $display("FAIL b2b_hold: got v=%b Out=%h acc=%b want v=1 Out=%h acc=0", out_valid, Out, acc, held);
    end
    r = ref_op(oa[2], ob[2], oo[2]);
    op3_acc = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || !op3_acc) && guard < 20) begin
      step(!op3_acc, oa[2], ob[2], oo[2], 1'b0, 1'b1, acc, ret, vld, rout);
      if (acc) begin op3_acc = 1'b1; exp_q.push_back(r[W-1:0]); end
      if (ret) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra: got Out=%h want none", rout); end
        else begin
          held = exp_q.pop_front();
          if (rout !== held) begin n_err++; $display("FAIL b2b_order: got Out=%h want %h", rout, held); end
        end
      end
      guard++;
    end
    n_vec++; if (exp_q.size() != 0 || !op3_acc) begin
      n_err++; $display("FAIL b2b_drain: got %0d pending accepted=%b want 0 pending accepted=1", exp_q.size(), op3_acc);
    end
    n_vec++; if ({V, N, Z} !== exp_flags) begin n_err++; $display("FAIL b2b_flags: got %b want %b", {V, N, Z}, exp_flags); end
  endtask

  task automatic test_reset_mid_stall();
    logic acc, ret, vld;
    logic [W-1:0] rout;
    step(1'b1, 16'h8000, 16'h0001, OP_SUB, 1'b1, 1'b1, acc, ret, vld, rout);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, ret, vld, rout);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, ret, vld, rout);
    n_vec++; if ({V, N, Z} !== 3'b110) begin n_err++; $display("FAIL rst_pre_flags: got %b want 110", {V, N, Z}); end
    step(1'b1, 16'h0005, 16'h0003, OP_ADD, 1'b1, 1'b0, acc, ret, vld, rout);
    step(1'b1, 16'h0006, 16'h0003, OP_ADD, 1'b1, 1'b0, acc, ret, vld, rout);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, acc, ret, vld, rout);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_stall_valid: got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({out_valid, V, N, Z} !== 4'b0000 || Out !== 16'h0000 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_async: got v=%b VNZ=%b Out=%h in_ready=%b want all 0",
                        out_valid, {V, N, Z}, Out, in_ready);
    end
    exp_flags = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0003, 16'h0004, OP_ADD, 1'b1, 1'b1, acc, ret, vld, rout);
    n_vec++; if (acc !== 1'b1 || vld !== 1'b0) begin
      n_err++; $display("FAIL rst_new_accept: got acc=%b v=%b want acc=1 v=0", acc, vld);
    end
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, ret, vld, rout);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc, ret, vld, rout);
    n_vec++; if (ret !== 1'b1 || rout !== 16'h0007 || {V, N, Z} !== 3'b000) begin
      n_err++; $display("FAIL rst_new_result: got ret=%b Out=%h VNZ=%b want ret=1 Out=0007 VNZ=000",
                        ret, rout, {V, N, Z});
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_stale: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_random(input int n_cycles);
    logic acc, ret, vld, iv, ordy, fwe, prev_stall;
    logic [W-1:0] rout, prev_out, a, b, e;
    logic [1:0] o;
    logic [W:0] r;
    logic [3:0] m;
    int guard;
    exp_q.delete();
    meta_q.delete();
    prev_stall = 1'b0;
    prev_out = '0;
    for (int c = 0; c < n_cycles + 60; c++) begin
      if (c >= n_cycles && exp_q.size() == 0) break;
      iv   = (c < n_cycles) && ($urandom_range(0, 9) < 7);
      ordy = (c >= n_cycles) || ($urandom_range(0, 9) < 7);
      a    = pick_operand();
      b    = pick_operand();
      o    = 2'($urandom_range(0, 3));
      fwe  = 1'($urandom_range(0, 1));
      step(iv, a, b, o, fwe, ordy, acc, ret, vld, rout);
      if (prev_stall) begin
        n_vec++; if (vld !== 1'b1 || rout !== prev_out) begin
          n_err++; $display("FAIL rnd_hold c%0d: got v=%b Out=%h want v=1 Out=%h", c, vld, rout, prev_out);
        end
      end
      prev_stall = vld && !ordy;
      prev_out = rout;
      if (ret) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_extra c%0d: got Out=%h want none", c, rout); end
        else begin
          e = exp_q.pop_front();
          m = meta_q.pop_front();
          if (rout !== e) begin n_err++; $display("FAIL rnd_result c%0d: got Out=%h want %h", c, rout, e); end
          if (m[3]) exp_flags = m[2:0];
        end
      end
      if (acc) begin
        r = ref_op(a, b, o);
        exp_q.push_back(r[W-1:0]);
        meta_q.push_back({fwe, r[W], r[W-1], (r[W-1:0] == '0)});
      end
      n_vec++; if ({V, N, Z} !== exp_flags) begin
        n_err++; $display("FAIL rnd_flags c%0d: got VNZ=%b want %b", c, {V, N, Z}, exp_flags);
      end
    end
    guard = exp_q.size();
    n_vec++; if (guard != 0) begin n_err++; $display("FAIL rnd_drain: got %0d pending want 0", guard); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_stall();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
